// File: rtl/conv_instr_pkg.sv
// Shared types for the queued conv instruction decoder: argument record layout,
// error flag positions, issue FSM states and the record sanity check.
package conv_instr_pkg;

    localparam int CONV_ARGS_W = 496;

    localparam int ERR_LEN   = 0;
    localparam int ERR_FIELD = 1;
    localparam int ERR_SPUR  = 2;
    localparam int ERR_FLUSH = 3;

    // First member is the MSB end: split size sits at [495:488], mode at [3:0].
    typedef struct packed {
        logic [7:0]   tiley_mid_tilex_mid_split_size;
        logic [263:0] tile_params;
        logic [7:0]   relu_en;
        logic [7:0]   quant_shift;
        logic [31:0]  quant_scale;
        logic [31:0]  out_addr;
        logic [31:0]  wgt_addr;
        logic [31:0]  in_addr;
        logic [15:0]  in_w;
        logic [15:0]  in_h;
        logic [15:0]  out_c;
        logic [15:0]  in_c;
        logic [3:0]   p;
        logic [3:0]   s;
        logic [3:0]   k;
        logic [3:0]   mode;
    } conv_args_t;

    typedef enum logic [1:0] {
        ISSUE_IDLE  = 2'd0,
        ISSUE_START = 2'd1,
        ISSUE_RUN   = 2'd2
    } issue_state_t;

    function automatic logic conv_args_ok(input conv_args_t a);
        logic ok;
        ok = (a.mode <= 4'd1)
          && (a.k >= 4'd1) && (a.k <= 4'd7)
          && (a.s >= 4'd1) && (a.s <= a.k)
          && (a.p < a.k);
        return ok;
    endfunction

endpackage

// File: rtl/conv_instr_fifo.sv
// SLOTS-deep register FIFO of argument records; head is always visible on
// head_data, flush empties it and wins over a same-cycle push or pop.
module conv_instr_fifo
    import conv_instr_pkg::*;
#(
    parameter int SLOTS = 2,
    parameter int CNT_W = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             push,
    input  conv_args_t       push_data,
    input  logic             pop,
    output conv_args_t       head_data,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(SLOTS - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(SLOTS);

    conv_args_t       mem_q [SLOTS];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && (count_q != FULL_CNT) && !flush;
    assign do_pop  = pop && (count_q != '0) && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Record storage carries no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule

// File: rtl/conv_instr_queue_decoder.sv
// Assembles multi-beat conv instructions into argument records, queues the
// valid ones and issues them to the conv engine one layer at a time.
module conv_instr_queue_decoder
    import conv_instr_pkg::*;
#(
    parameter int BUS_W  = 64,
    parameter int ARGS_W = 512,
    parameter int SLOTS  = 2,
    parameter int CNT_W  = $clog2(SLOTS + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_last,
    input  logic             flush,
    input  logic             layer_done,
    input  logic             err_clr,
    output logic             conv_start,
    output conv_args_t       cur_args,
    output logic             busy,
    output logic [CNT_W-1:0] q_count,
    output logic [3:0]       err,
    output issue_state_t     dbg_state
);

    localparam int BEATS = ARGS_W / BUS_W;
    localparam int BC_W  = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BC_W-1:0]  BC_LAST  = BC_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SLOTS);

    logic [BC_W-1:0]   bc_q, bc_d;
    logic              discard_q, discard_d;
    logic [ARGS_W-1:0] asm_q, asm_d;
    logic [3:0]        err_q, err_d;

    issue_state_t      state_q, state_d;
    logic              conv_start_q, conv_start_d;
    logic              busy_q, busy_d;
    conv_args_t        cur_args_q, cur_args_d;

    logic              beat_acc;
    logic              commit;
    logic              len_err;
    logic              field_err;
    logic              spur_err;
    logic              flush_drop;
    logic              pop;
    conv_args_t        rec;
    conv_args_t        head;
    logic [CNT_W-1:0]  fifo_count;
    logic [3:0]        new_err;

    // Only the final beat of a record can stall; discarded beats always drain.
    assign in_ready = discard_q || !((bc_q == BC_LAST) && (fifo_count == CNT_FULL));
    assign beat_acc = in_valid && in_ready;

    always_comb begin
        bc_d      = bc_q;
        discard_d = discard_q;
        asm_d     = asm_q;
        commit    = 1'b0;
        len_err   = 1'b0;
        field_err = 1'b0;
        if (beat_acc && !discard_q) begin
            for (int i = 0; i < BEATS; i++) begin
                if (bc_q == BC_W'(i)) begin
                    asm_d[i*BUS_W +: BUS_W] = in_data;
                end
            end
        end
        rec = conv_args_t'(asm_d[CONV_ARGS_W-1:0]);
        if (flush) begin
            bc_d      = '0;
            discard_d = 1'b0;
        end else if (beat_acc) begin
            if (discard_q) begin
                if (in_last) begin
                    discard_d = 1'b0;
                end
            end else if (bc_q == BC_LAST) begin
                bc_d = '0;
                if (in_last) begin
                    if (conv_args_ok(rec)) begin
                        commit = 1'b1;
                    end else begin
                        field_err = 1'b1;
                    end
                end else begin
                    len_err   = 1'b1;
                    discard_d = 1'b1;
                end
            end else if (in_last) begin
                bc_d    = '0;
                len_err = 1'b1;
            end else begin
                bc_d = bc_q + BC_W'(1);
            end
        end
    end

    conv_instr_fifo #(
        .SLOTS (SLOTS),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush),
        .push      (commit),
        .push_data (rec),
        .pop       (pop),
        .head_data (head),
        .count     (fifo_count)
    );

    // A flush never pops, so the queue it clears cannot feed a new start.
    always_comb begin
        state_d      = state_q;
        conv_start_d = 1'b0;
        busy_d       = busy_q;
        cur_args_d   = cur_args_q;
        pop          = 1'b0;
        spur_err     = 1'b0;
        case (state_q)
            ISSUE_IDLE: begin
                spur_err = layer_done;
                if ((fifo_count != '0) && !flush) begin
                    pop          = 1'b1;
                    cur_args_d   = head;
                    conv_start_d = 1'b1;
                    busy_d       = 1'b1;
                    state_d      = ISSUE_START;
                end
            end
            ISSUE_START: begin
                spur_err = layer_done;
                state_d  = ISSUE_RUN;
            end
            ISSUE_RUN: begin
                if (layer_done) begin
                    if ((fifo_count != '0) && !flush) begin
                        pop          = 1'b1;
                        cur_args_d   = head;
                        conv_start_d = 1'b1;
                        state_d      = ISSUE_START;
                    end else begin
                        busy_d  = 1'b0;
                        state_d = ISSUE_IDLE;
                    end
                end
            end
            default: begin
                busy_d  = 1'b0;
                state_d = ISSUE_IDLE;
            end
        endcase
    end

    assign flush_drop = flush && ((bc_q != '0) || (fifo_count != '0));

    always_comb begin
        new_err            = '0;
        new_err[ERR_LEN]   = len_err;
        new_err[ERR_FIELD] = field_err;
        new_err[ERR_SPUR]  = spur_err;
        new_err[ERR_FLUSH] = flush_drop;
        err_d = (err_clr ? 4'd0 : err_q) | new_err;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bc_q      <= '0;
            discard_q <= 1'b0;
            asm_q     <= '0;
            err_q     <= '0;
        end else begin
            bc_q      <= bc_d;
            discard_q <= discard_d;
            asm_q     <= asm_d;
            err_q     <= err_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ISSUE_IDLE;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            cur_args_q   <= '0;
        end else begin
            state_q      <= state_d;
            conv_start_q <= conv_start_d;
            busy_q       <= busy_d;
            cur_args_q   <= cur_args_d;
        end
    end

    assign conv_start = conv_start_q;
    assign cur_args   = cur_args_q;
    assign busy       = busy_q;
    assign q_count    = fifo_count;
    assign err        = err_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_conv_instr_queue_decoder.sv
// Bench for conv_instr_queue_decoder: directed timing scenarios plus random
// instruction streams scored against an instruction-level reference model.
module tb_conv_instr_queue_decoder;
  import conv_instr_pkg::*;

  localparam int BUS_W  = 64;
  localparam int ARGS_W = 512;
  localparam int SLOTS  = 2;
  localparam int BEATS  = ARGS_W / BUS_W;
  localparam int CNT_W  = $clog2(SLOTS + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic             in_valid;
  logic             in_ready;
  logic [BUS_W-1:0] in_data;
  logic             in_last;
  logic             flush;
  logic             layer_done;
  logic             err_clr;
  logic             conv_start;
  conv_args_t       cur_args;
  logic             busy;
  logic [CNT_W-1:0] q_count;
  logic [3:0]       err;
  issue_state_t     dbg_state;

  logic eng_ld = 1'b0;
  logic man_ld = 1'b0;
  bit   auto_eng = 1'b0;
  assign layer_done = eng_ld | man_ld;

  conv_instr_queue_decoder #(
    .BUS_W  (BUS_W),
    .ARGS_W (ARGS_W),
    .SLOTS  (SLOTS)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_last    (in_last),
    .flush      (flush),
    .layer_done (layer_done),
    .err_clr    (err_clr),
    .conv_start (conv_start),
    .cur_args   (cur_args),
    .busy       (busy),
    .q_count    (q_count),
    .err        (err),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int n_starts = 0;
  int n_pushed = 0;
  logic [CONV_ARGS_W-1:0] exp_q[$];
  logic [3:0] exp_err = 4'd0;
  logic [ARGS_W-1:0] w;

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic bit ref_ok(input logic [ARGS_W-1:0] r);
    int mode = int'(r[3:0]);
    int k = int'(r[7:4]);
    int s = int'(r[11:8]);
    int p = int'(r[15:12]);
    return (mode <= 1) && (k >= 1) && (k <= 7) && (s >= 1) && (s <= k) && (p < k);
  endfunction

  function automatic logic [ARGS_W-1:0] make_rec(input int mode, input int k, input int s, input int p);
    logic [ARGS_W-1:0] r;
    for (int i = 0; i < ARGS_W / 32; i++) r[i*32 +: 32] = $urandom();
    r[3:0]   = mode[3:0];
    r[7:4]   = k[3:0];
    r[11:8]  = s[3:0];
    r[15:12] = p[3:0];
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [BUS_W-1:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check_eq("in_ready_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic send_instr(input logic [ARGS_W-1:0] r, input int len);
    for (int b = 0; b < len; b++) begin
      if (auto_eng && $urandom_range(0, 4) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(r[(b % BEATS)*BUS_W +: BUS_W], b == len - 1);
    end
    if (len != BEATS) exp_err[ERR_LEN] = 1'b1;
    else if (ref_ok(r)) begin
      exp_q.push_back(r[CONV_ARGS_W-1:0]);
      n_pushed++;
    end else exp_err[ERR_FIELD] = 1'b1;
  endtask

  task automatic pulse_ld();
    man_ld = 1'b1;
    @(posedge clk);
    #1;
    man_ld = 1'b0;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    exp_err = 4'd0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || q_count != 0) && n < 50) begin
      repeat (2) @(posedge clk);
      #1;
      pulse_ld();
      n++;
    end
    check_eq("drain_done", (busy || q_count != 0), 0);
  endtask

  // Every start must carry the oldest expected record.
  always @(negedge clk) begin
    if (reset_n && conv_start) begin
      n_starts++;
      check_eq("busy_at_start", busy, 1);
      check_eq("start_has_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) check_eq("cur_args", cur_args, exp_q.pop_front());
    end
  end

  // Random-latency conv engine model.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_eng && reset_n && conv_start) begin
        repeat ($urandom_range(1, 5)) @(posedge clk);
        #1 eng_ld = 1'b1;
        @(posedge clk);
        #1 eng_ld = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int r, len, k;
    in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    flush = 1'b0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    @(negedge clk);
    check_eq("rst_conv_start", conv_start, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_q_count", q_count, 0);
    check_eq("rst_err", err, 0);
    check_eq("rst_cur_args", cur_args, 0);
    check_eq("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Basic issue latency
    send_instr(make_rec(0, 3, 1, 1), BEATS);
    @(negedge clk);
    check_eq("t1_q_count_after_commit", q_count, 1);
    check_eq("t1_no_early_start", conv_start, 0);
    @(negedge clk);
    check_eq("t1_conv_start", conv_start, 1);
    check_eq("t1_k", cur_args.k, 3);
    check_eq("t1_busy", busy, 1);
    check_eq("t1_q_count", q_count, 0);
    @(negedge clk);
    check_eq("t1_start_one_cycle", conv_start, 0);
    @(posedge clk);
    #1;
    pulse_ld();
    @(negedge clk);
    check_eq("t1_busy_fall", busy, 0);
    @(posedge clk);
    #1;

    // Short instruction, then a normal one
    send_instr(make_rec(1, 5, 2, 4), 5);
    @(negedge clk);
    check_eq("t2_len_err", err, exp_err);
    check_eq("t2_q_count", q_count, 0);
    @(posedge clk);
    #1;
    send_instr(make_rec(1, 5, 2, 4), BEATS);
    repeat (2) @(negedge clk);
    check_eq("t2_conv_start", conv_start, 1);
    @(posedge clk);
    #1;
    pulse_ld();

    // Field errors
    send_instr(make_rec(0, 0, 1, 0), BEATS);
    @(negedge clk);
    check_eq("t3_k0_err", err, exp_err);
    @(posedge clk);
    #1;
    clear_err();
    send_instr(make_rec(0, 3, 4, 1), BEATS);
    @(negedge clk);
    check_eq("t3_s_gt_k_err", err, exp_err);
    check_eq("t3_q_count", q_count, 0);
    check_eq("t3_not_busy", busy, 0);
    @(posedge clk);
    #1;
    clear_err();

    // Queue full stalls the final beat
    send_instr(make_rec(0, 3, 1, 1), BEATS);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    send_instr(make_rec(1, 7, 7, 6), BEATS);
    send_instr(make_rec(0, 1, 1, 0), BEATS);
    w = make_rec(1, 4, 2, 3);
    for (int b = 0; b < BEATS - 1; b++) send_beat(w[b*BUS_W +: BUS_W], 1'b0);
    in_valid = 1'b1;
    in_data  = w[(BEATS-1)*BUS_W +: BUS_W];
    in_last  = 1'b1;
    @(negedge clk);
    check_eq("t4_full_q_count", q_count, 2);
    check_eq("t4_full_in_ready", in_ready, 0);
    @(posedge clk);
    #1 man_ld = 1'b1;
    @(posedge clk);
    #1 man_ld = 1'b0;
    @(negedge clk);
    check_eq("t4_b2b_start", conv_start, 1);
    check_eq("t4_pop_q_count", q_count, 1);
    check_eq("t4_unstall", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    exp_q.push_back(w[CONV_ARGS_W-1:0]);
    n_pushed++;
    @(negedge clk);
    check_eq("t4_refill_q_count", q_count, 2);
    check_eq("t4_start_pulse_end", conv_start, 0);
    @(posedge clk);
    #1;
    drain();
    check_eq("t4_err_clean", err, 0);

    // Spurious layer_done
    pulse_ld();
    exp_err[ERR_SPUR] = 1'b1;
    @(negedge clk);
    check_eq("t5_spur_err", err, exp_err);
    check_eq("t5_busy", busy, 0);
    check_eq("t5_q_count", q_count, 0);
    check_eq("t5_no_start", conv_start, 0);
    @(posedge clk);
    #1;
    clear_err();
    @(negedge clk);
    check_eq("t5_err_clr", err, 0);
    @(posedge clk);
    #1;

    // Flush drops a queued record but not the running layer
    send_instr(make_rec(0, 2, 2, 1), BEATS);
    send_instr(make_rec(1, 6, 3, 5), BEATS);
    @(negedge clk);
    check_eq("t6_q_before_flush", q_count, 1);
    @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    void'(exp_q.pop_back());
    n_pushed--;
    exp_err[ERR_FLUSH] = 1'b1;
    @(negedge clk);
    check_eq("t6_flush_q_count", q_count, 0);
    check_eq("t6_flush_err", err, exp_err);
    check_eq("t6_busy_kept", busy, 1);
    @(posedge clk);
    #1;
    drain();
    clear_err();

    // Random stream with auto engine
    auto_eng = 1'b1;
    for (int i = 0; i < 30; i++) begin
      r = $urandom_range(0, 9);
      len = BEATS;
      if (r < 6) begin
        k = $urandom_range(1, 7);
        w = make_rec($urandom_range(0, 1), k, $urandom_range(1, k), $urandom_range(0, k - 1));
      end else begin
        w = make_rec($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15));
        if (r == 7) len = $urandom_range(1, BEATS - 1);
        if (r == 8) len = $urandom_range(BEATS + 1, BEATS + 3);
      end
      send_instr(w, len);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 6)) @(posedge clk);
      #1;
    end
    begin
      int n = 0;
      while ((busy || q_count != 0 || exp_q.size() != 0) && n < 1000) begin
        @(posedge clk);
        n++;
      end
    end
    #1;
    check_eq("rand_drained", (busy || q_count != 0 || exp_q.size() != 0), 0);
    check_eq("rand_err", err, exp_err);
    check_eq("rand_start_count", n_starts, n_pushed);
    auto_eng = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Asynchronous reset mid-instruction and mid-layer
    send_instr(make_rec(0, 3, 1, 1), 3);
    send_instr(make_rec(0, 5, 5, 4), BEATS);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    w = make_rec(1, 2, 1, 1);
    for (int b = 0; b < 5; b++) send_beat(w[b*BUS_W +: BUS_W], 1'b0);
    in_valid = 1'b1;
    in_data  = w[5*BUS_W +: BUS_W];
    @(negedge clk);
    check_eq("t8_pre_busy", busy, 1);
    check_eq("t8_pre_err", err != 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("t8_rst_conv_start", conv_start, 0);
    check_eq("t8_rst_busy", busy, 0);
    check_eq("t8_rst_q_count", q_count, 0);
    check_eq("t8_rst_err", err, 0);
    check_eq("t8_rst_cur_args", cur_args, 0);
    check_eq("t8_rst_in_ready", in_ready, 1);
    in_valid = 1'b0;
    n_pushed -= exp_q.size();
    exp_q.delete();
    exp_err = 4'd0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk);
    #1;
    w = make_rec(1, 6, 2, 0);
    send_instr(w, BEATS);
    repeat (2) @(negedge clk);
    check_eq("t8_post_start", conv_start, 1);
    check_eq("t8_post_args", cur_args, w[CONV_ARGS_W-1:0]);
    @(posedge clk);
    #1;
    pulse_ld();
    @(negedge clk);
    check_eq("t8_post_busy", busy, 0);
    check_eq("t8_post_err", err, 0);
    check_eq("final_exp_empty", exp_q.size(), 0);
    check_eq("final_start_count", n_starts, n_pushed);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/conv_instr_queue_decoder.md
# conv_instr_queue_decoder

Parametrised successor to the single-shot conv instruction decoder. It receives conv/quantize/relu layer instructions as multi-beat streams over a narrow bus and assembles each into a 496-bit argument record. It sanity-checks the record and queues up to SLOTS records, then issues them one at a time to the conv engine with a `conv_start` pulse. This lets the next layer's arguments be preloaded while the current layer runs, giving back-to-back layer starts without a controller round-trip.

## Interface
- BUS_W, 64: instruction beat width; must divide ARGS_W.
- ARGS_W, 512: instruction record width; BEATS = ARGS_W/BUS_W (default 8).
- SLOTS, 2: queued-record depth; power of 2, at least 1.
- clk  in  1  single clock; all flops on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  BUS_W  beat payload; beat 0 carries bits [BUS_W-1:0].
- in_last  in  1  marks the final beat of an instruction.
- flush  in  1  synchronous clear of the assembler and queue; does not abort a running layer.
- layer_done  in  1  one-cycle pulse from the conv engine when the current layer completes.
- err_clr  in  1  clears `err`.
- conv_start  out  1  one-cycle start pulse to the conv engine.
- cur_args  out  conv_args_t (496)  arguments of the issued layer; stable from `conv_start` until the next `conv_start`.
- busy  out  1  high from `conv_start` until the matching `layer_done`.
- q_count  out  $clog2(SLOTS+1)  number of queued, not-yet-issued records.
- err  out  4  sticky error flags:
  - bit 0: length error.
  - bit 1: field error.
  - bit 2: spurious `layer_done`.
  - bit 3: flush dropped data.

## Operation
- **Assembler, beat counter `bc` (0..BEATS-1):**
  - Each accepted beat writes `in_data` into slice `bc` of the assembly register.
  - Accepted beat with `bc==BEATS-1` and `in_last`: commit, set `bc` to 0.
  - `in_last` with `bc<BEATS-1`: discard the record, set err[0], set `bc` to 0.
  - `bc==BEATS-1` without `in_last`: discard the record, set err[0], enter DISCARD.
  - DISCARD: drops beats up to and including the next `in_last`, then returns to `bc=0`.
- **Commit check, on assembled bits:**
  - Fields: mode=[3:0], k=[7:4], s=[11:8], p=[15:12].
  - Record is valid iff mode≤1, 1≤k≤7, 1≤s≤k, p<k.
  - Invalid: drop the record, set err[1].
  - Bits [ARGS_W-1:496] are reserved and ignored.
- **`in_ready`:** `!(bc==BEATS-1 && q_count==SLOTS)`, i.e. it stalls only the final beat while the queue is full. It is 1 in DISCARD.
- **Issue FSM:**
  - IDLE: if `q_count>0`, pop the head into `cur_args` and go to START.
  - START: `conv_start=1` for this cycle; go to RUN.
  - RUN: on `layer_done`, pop the head and go to START if the queue is non-empty, else go to IDLE.
  - `layer_done` outside RUN is ignored and sets err[2].
- **Simultaneous events:**
  - Commit and pop in the same cycle: `q_count` is unchanged.
  - `flush` wins over a same-cycle commit. It sets err[3] if the queue or assembler held data.
  - `err_clr` loses to a same-cycle new error.
- **Reset** (asynchronous, including mid-instruction or mid-layer):
  - `conv_start`, `busy`, `q_count`, `err` go to 0; `cur_args` goes to all-zero.
  - FSM goes to IDLE; `bc` goes to 0; DISCARD is cleared; `in_ready` is 1.
  - A layer already running in the engine is not tracked after reset.

## Timing
- Final-beat handshake at edge t, queue previously empty and FSM in IDLE: `q_count`=1 after t. The pop happens at edge t+1; `conv_start` and new `cur_args` are visible in the cycle after t+1, i.e. 2 cycles after the handshake.
- Back-to-back: `layer_done` sampled at edge t in RUN with the queue non-empty gives `conv_start` in the cycle after t, with no idle gap.
- `busy` rises with `conv_start` and falls the cycle after the `layer_done` edge.
- `err` bits update one cycle after the causing beat.
- All outputs are registered except `in_ready`, which is combinational from `bc` and `q_count` only (no path from `in_valid`).

## Structure
- **Package `conv_instr_pkg`:**
  - `conv_args_t` packed struct holding the existing field layout: mode[3:0] at bit 0 through tiley_mid_tilex_mid_split_size at [495:488].
  - `CONV_ARGS_W`=496.
  - Err bit index constants.
  - Function `conv_args_ok(conv_args_t)` implementing the commit check.
- **Sub-module `conv_instr_fifo`:** SLOTS-deep register FIFO of `conv_args_t`, with push/pop/count and a flush input.
- **Top level:** holds the assembler, DISCARD flag and issue FSM.

## Test plan
- Reset, then 8 beats encoding mode=0, k=3, s=1, p=1, `in_last` on beat 7 → `conv_start` pulse 2 cycles after the final beat; `cur_args.k`=3, `busy`=1, `q_count`=0.
- `in_last` on beat 4 → no commit, err[0]=1, `q_count`=0; the next well-formed instruction is issued normally.
- Record with k=0 → dropped, err[1]=1; record with s=4, k=3 → dropped.
- SLOTS=2, layer running, 3 more instructions sent with no `layer_done` → `q_count`=2 and `in_ready`=0 on the 3rd final beat. After `layer_done`: `conv_start` the next cycle, then the stalled beat is accepted and `q_count` returns to 2.
- `layer_done` while IDLE → err[2]=1, no state change; `err_clr` → `err`=0.
- `reset_n` low asynchronously at beat 5 → all outputs 0 immediately; after release, a full 8-beat instruction starting at beat 0 issues correctly.
